gte_mac_unit: RTL



---
 rtl/gte_mac_unit.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/gte_mac_unit.sv
// Three-lane signed 16x16 multiply-accumulate stage: 44-bit wrapping accumulator, optional >>>12, IR clamp.
// Define GTE_MAC_FLAGS_EN to generate MAC overflow / IR saturation flags; otherwise o_flags reads 0.

module gte_mac_lane #(
    parameter int ACC_W = 44,
    parameter int MAC_W = 32
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               beat,
    input  logic signed [15:0] mulA,
    input  logic signed [15:0] mulB,
    input  logic signed [31:0] add,
    input  logic               pVld,
    input  logic               pStart,
    input  logic               pAddEn,
    input  logic               aLast,
    input  logic               aSf,
    input  logic               rVld,
    input  logic               rLm,
    output logic [MAC_W-1:0]   mac,
    output logic [15:0]        ir
`ifdef GTE_MAC_FLAGS_EN
    ,
    output logic [2:0]         flags
`endif
);
`ifdef GTE_MAC_FLAGS_EN
    localparam int SUM_W = ACC_W + 4;
`else
    // Without flags the guard bits would never be looked at; the low bits wrap identically.
    localparam int SUM_W = ACC_W;
`endif
    localparam logic signed [ACC_W-1:0] IR_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] IR_MIN = ACC_W'(-32768);

    logic signed [31:0]      pProd, pAdd;
    logic signed [ACC_W-1:0] acc, shifted, irLo;
    logic signed [SUM_W-1:0] base, sum;
    logic                    hiSat, loSat;
    logic [15:0]             irVal;

    always_comb begin
        base  = pAddEn ? (SUM_W'(pAdd) <<< 12) : '0;
        sum   = (pStart ? base : SUM_W'(acc)) + SUM_W'(pProd);
        irLo  = rLm ? '0 : IR_MIN;
        hiSat = shifted > IR_MAX;
        loSat = shifted < irLo;
        irVal = hiSat ? 16'h7FFF : (loSat ? irLo[15:0] : shifted[15:0]);
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            pProd   <= '0;
            pAdd    <= '0;
            acc     <= '0;
            shifted <= '0;
            mac     <= '0;
            ir      <= '0;
        end else begin
            if (beat) begin
                pProd <= 32'(mulA) * 32'(mulB);
                pAdd  <= add;
            end
            if (pVld)  acc     <= sum[ACC_W-1:0];
            if (aLast) shifted <= aSf ? (acc >>> 12) : acc;
            if (rVld) begin
                mac <= shifted[MAC_W-1:0];
                ir  <= irVal;
            end
        end
    end

`ifdef GTE_MAC_FLAGS_EN
    logic posC, negC, accPos, accNeg, rPos, rNeg;

    // Sum leaves the signed ACC_W range when the guard bits disagree with the top accumulator bit.
    assign posC = ~sum[SUM_W-1] & (|sum[SUM_W-2:ACC_W-1]);
    assign negC =  sum[SUM_W-1] & ~(&sum[SUM_W-2:ACC_W-1]);

    always_ff @(posedge clk) begin
        if (!nRst) begin
            accPos <= 1'b0;
            accNeg <= 1'b0;
            rPos   <= 1'b0;
            rNeg   <= 1'b0;
            flags  <= '0;
        end else begin
            if (pVld) begin
                accPos <= posC | (accPos & ~pStart);
                accNeg <= negC | (accNeg & ~pStart);
            end
            if (aLast) begin
                rPos <= accPos;
                rNeg <= accNeg;
            end
            if (rVld) flags <= {rPos, rNeg, hiSat | loSat};
        end
    end
`endif
endmodule

module gte_mac_unit #(
    parameter int ACC_W = 44,
    parameter int MAC_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_nRst,
    input  logic                  i_valid,
    input  logic                  i_start,
    input  logic                  i_last,
    input  logic                  i_sf,
    input  logic                  i_lm,
    input  logic [2:0][15:0]      i_mulA,
    input  logic [2:0][15:0]      i_mulB,
    input  logic                  i_addEn,
    input  logic [2:0][31:0]      i_add,
    output logic                  o_valid,
    output logic [2:0][MAC_W-1:0] o_mac,
    output logic [2:0][15:0]      o_ir,
    output logic [8:0]            o_flags
);
    localparam int NUM_LANES = 3;
    localparam int STAGES    = 2;

    logic               pVld, pStart, pLast, pSf, pLm, pAddEn, aSf, aLm, rLm;
    logic [STAGES:0]    vldPipe;  // [0] last beat accumulated, [1] shifted, [2] result out

    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            pVld    <= 1'b0;
            pStart  <= 1'b0;
            pLast   <= 1'b0;
            pSf     <= 1'b0;
            pLm     <= 1'b0;
            pAddEn  <= 1'b0;
            aSf     <= 1'b0;
            aLm     <= 1'b0;
            rLm     <= 1'b0;
            vldPipe <= '0;
        end else begin
            pVld <= i_valid;
            if (i_valid) begin
                pStart <= i_start;
                pLast  <= i_last;
                pSf    <= i_sf;
                pLm    <= i_lm;
                pAddEn <= i_addEn;
            end
            vldPipe <= {vldPipe[STAGES-1:0], pVld & pLast};
            if (pVld & pLast) begin
                aSf <= pSf;
                aLm <= pLm;
            end
            if (vldPipe[0]) rLm <= aLm;
        end
    end

    assign o_valid = vldPipe[STAGES];

`ifdef GTE_MAC_FLAGS_EN
    logic [NUM_LANES-1:0][2:0] laneFlags;
`endif

    for (genvar n = 0; n < NUM_LANES; n++) begin : gLane
        gte_mac_lane #(.ACC_W(ACC_W), .MAC_W(MAC_W)) uLane (
            .clk    (i_clk),
            .nRst   (i_nRst),
            .beat   (i_valid),
            .mulA   (i_mulA[n]),
            .mulB   (i_mulB[n]),
            .add    (i_add[n]),
            .pVld   (pVld),
            .pStart (pStart),
            .pAddEn (pAddEn),
            .aLast  (vldPipe[0]),
            .aSf    (aSf),
            .rVld   (vldPipe[1]),
            .rLm    (rLm),
            .mac    (o_mac[n]),
            .ir     (o_ir[n])
`ifdef GTE_MAC_FLAGS_EN
            ,
            .flags  (laneFlags[n])
`endif
        );
    end

`ifdef GTE_MAC_FLAGS_EN
    always_comb begin
        o_flags = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            o_flags[6+n] = laneFlags[n][2];
            o_flags[3+n] = laneFlags[n][1];
            o_flags[n]   = laneFlags[n][0];
        end
    end
`else
    assign o_flags = '0;
`endif
endmodule
